// File: rtl/reduce_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reduce_pipe_pkg
// Description : Shared op encoding, pairwise operator and log2 helper for the
//               pipelined reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
package reduce_pipe_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    // NAND combines with AND inside the tree; the inversion is applied once at the root.
    function automatic logic pair_op(input logic [1:0] op, input logic x, input logic y);
        case (op)
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return x & y;
        endcase
    endfunction

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_stage.sv
`default_nettype none
// ============================================================================
// Module      : reduce_stage
// Description : One registered tree level: N bits reduced pairwise to N/2,
//               with valid and op carried alongside the data.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_stage
    import reduce_pipe_pkg::*;
#(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           adv_i,
    input  logic           valid_i,
    input  logic [1:0]     op_i,
    input  logic [N-1:0]   data_i,
    output logic           valid_o,
    output logic [1:0]     op_o,
    output logic [N/2-1:0] data_o
);

    logic           valid_q;
    logic [1:0]     op_q;
    logic [N/2-1:0] data_q;
    logic [N/2-1:0] data_d;

    always_comb begin
        data_d = '0;
        for (int j = 0; j < N / 2; j++) begin
            data_d[j] = pair_op(op_i, data_i[2*j], data_i[2*j+1]);
        end
        if (N == 2 && op_i == OP_NAND) begin
            data_d = ~data_d;
        end
    end

    // Data and op only load on real transactions so bubbles leave the root value intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= 2'b00;
            data_q  <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                op_q   <= op_i;
                data_q <= data_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : reduce_pipe
// Description : Pipelined AND/OR/XOR/NAND reduction tree with valid/ready
//               flow control and a delivered-result counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_pipe
    import reduce_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result_count
);

    localparam int LEVELS = log2(WIDTH);

    // All levels packed back to back: level k occupies WIDTH>>k bits at 2*WIDTH - 2*(WIDTH>>k).
    logic [2*WIDTH-2:0]     w_tree;
    logic [LEVELS:0]        w_valid;
    logic [LEVELS:0][1:0]   w_op;
    logic                   w_stall;
    logic                   w_adv;
    logic                   w_unused_op;
    logic [CNT_W-1:0]       result_count_q;
    logic [CNT_W-1:0]       result_count_d;

    assign w_stall  = out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = w_adv;

    assign w_tree[WIDTH-1:0] = a;
    assign w_valid[0]        = in_valid;
    assign w_op[0]           = op;

    generate
        for (genvar k = 1; k <= LEVELS; k++) begin : g_level
            localparam int N_IN    = WIDTH >> (k - 1);
            localparam int OFF_IN  = 2 * WIDTH - 2 * N_IN;
            localparam int OFF_OUT = OFF_IN + N_IN;

            reduce_stage #(
                .N (N_IN)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .adv_i   (w_adv),
                .valid_i (w_valid[k-1]),
                .op_i    (w_op[k-1]),
                .data_i  (w_tree[OFF_IN +: N_IN]),
                .valid_o (w_valid[k]),
                .op_o    (w_op[k]),
                .data_o  (w_tree[OFF_OUT +: N_IN/2])
            );
        end
    endgenerate

    assign w_unused_op = ^w_op[LEVELS];

    always_comb begin
        result_count_d = result_count_q;
        if (out_valid && out_ready) begin
            result_count_d = result_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_count_q <= '0;
        end else begin
            result_count_q <= result_count_d;
        end
    end

    assign b            = w_tree[2*WIDTH-2];
    assign out_valid    = w_valid[LEVELS];
    assign result_count = result_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_reduce_pipe
// Description : Directed and model-checked bench for reduce_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reduce_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 stimulus, shared by the CNT_W=16 and CNT_W=4 instances
    logic [7:0]  a;
    logic [1:0]  op;
    logic        in_valid, out_ready;
    logic        in_ready, b, out_valid;
    logic [15:0] result_count;
    logic        in_ready_w, b_w, out_valid_w;
    logic [3:0]  result_count_w;

    // WIDTH=2 and WIDTH=32 sweep instances
    logic [1:0]  s2_a;
    logic [1:0]  s2_op;
    logic        s2_iv, s2_rdy, s2_ir, s2_b, s2_ov;
    logic [15:0] s2_rc;
    logic [31:0] s32_a;
    logic [1:0]  s32_op;
    logic        s32_iv, s32_rdy, s32_ir, s32_b, s32_ov;
    logic [15:0] s32_rc;

    int n_checks = 0;
    int n_fail   = 0;

    reduce_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .op(op), .in_valid(in_valid),
        .in_ready(in_ready), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result_count(result_count)
    );

    reduce_pipe #(.WIDTH(8), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .a(a), .op(op), .in_valid(in_valid),
        .in_ready(in_ready_w), .b(b_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .result_count(result_count_w)
    );

    reduce_pipe #(.WIDTH(2), .CNT_W(16)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .a(s2_a), .op(s2_op), .in_valid(s2_iv),
        .in_ready(s2_ir), .b(s2_b), .out_valid(s2_ov),
        .out_ready(s2_rdy), .result_count(s2_rc)
    );

    reduce_pipe #(.WIDTH(32), .CNT_W(16)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .a(s32_a), .op(s32_op), .in_valid(s32_iv),
        .in_ready(s32_ir), .b(s32_b), .out_valid(s32_ov),
        .out_ready(s32_rdy), .result_count(s32_rc)
    );

    // Linear (non-tree) reference reduction over the low w bits
    function automatic logic ref_red(input logic [1:0] o, input logic [31:0] v, input int w);
        logic r;
        r = (o == 2'd1 || o == 2'd2) ? 1'b0 : 1'b1;
        for (int i = 0; i < w; i++) begin
            case (o)
                2'd1:    r = r | v[i];
                2'd2:    r = r ^ v[i];
                default: r = r & v[i];
            endcase
        end
        if (o == 2'd3) r = ~r;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        s2_iv = 1'b0; s32_iv = 1'b0; s2_rdy = 1'b0; s32_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
        s2_a = '0; s2_op = '0; s2_iv = 1'b0; s2_rdy = 1'b0;
        s32_a = '0; s32_op = '0; s32_iv = 1'b0; s32_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got %b expected 0", b); end
        n_checks++; if (result_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", result_count); end
        n_checks++; if (result_count_w !== 4'd0) begin n_fail++; $display("FAIL reset_count_w: got %0d expected 0", result_count_w); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] va [4];
        logic [1:0] vo [4];
        logic       ve [4];
        va = '{8'hFF, 8'hFE, 8'hFE, 8'h00};
        vo = '{2'd0, 2'd0, 2'd3, 2'd1};
        ve = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = va[i]; op = vo[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accept[%0d]: got %b expected 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early[%0d]: got %b expected 0", i, out_valid); end
            @(negedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (b !== ve[i]) begin n_fail++; $display("FAIL basic_b[%0d]: got %b expected %b", i, b, ve[i]); end
            @(negedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain[%0d]: got %b expected 0", i, out_valid); end
            n_checks++; if (b !== ve[i]) begin n_fail++; $display("FAIL basic_b_hold[%0d]: got %b expected %b", i, b, ve[i]); end
        end
    endtask

    task automatic test_op_tracking();
        logic [7:0] va [4];
        logic [1:0] vo [4];
        logic       ve [4];
        va = '{8'h01, 8'h03, 8'h80, 8'h00};
        vo = '{2'd2, 2'd2, 2'd1, 2'd3};
        ve = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t < 4) begin
                a = va[t]; op = vo[t]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t >= 3 && t <= 6) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL optrack_valid[%0d]: got %b expected 1", t - 3, out_valid); end
                n_checks++; if (b !== ve[t-3]) begin n_fail++; $display("FAIL optrack_b[%0d]: got %b expected %b", t - 3, b, ve[t-3]); end
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL optrack_idle: got %b expected 0", out_valid); end
        n_checks++; if (result_count !== 16'd4) begin n_fail++; $display("FAIL optrack_count: got %0d expected 4", result_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] va [4];
        logic [1:0] vo [4];
        logic       ve [4];
        va = '{8'hFF, 8'h01, 8'h0F, 8'h07};
        vo = '{2'd0, 2'd0, 2'd2, 2'd2};
        ve = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            if (t < 3) begin
                a = va[t]; op = vo[t]; in_valid = 1'b1;
            end else if (t <= 8) begin
                a = va[3]; op = vo[3]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(t >= 3 && t <= 7);
            #1;
            if (t >= 3 && t <= 7) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", t, in_ready); end
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", t, out_valid); end
                n_checks++; if (b !== ve[0]) begin n_fail++; $display("FAIL bp_b_hold[%0d]: got %b expected %b", t, b, ve[0]); end
            end
            if (t >= 8 && t <= 11) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid[%0d]: got %b expected 1", t - 8, out_valid); end
                n_checks++; if (b !== ve[t-8]) begin n_fail++; $display("FAIL bp_release_b[%0d]: got %b expected %b", t - 8, b, ve[t-8]); end
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b expected 0", out_valid); end
        n_checks++; if (result_count !== 16'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", result_count); end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] va [3];
        va = '{8'h01, 8'h00, 8'hFF};
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            a = va[t]; op = 2'd1; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mf_pre_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mf_valid_cleared: got %b expected 0", out_valid); end
        n_checks++; if (result_count !== 16'd0) begin n_fail++; $display("FAIL mf_count_cleared: got %0d expected 0", result_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mf_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'hFF; op = 2'd0; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mf_first_accept: got %b expected 1", in_ready); end
        for (int t = 5; t <= 10; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_checks++; if (out_valid !== (t == 7)) begin n_fail++; $display("FAIL mf_single_result[t=%0d]: got %b expected %b", t, out_valid, (t == 7)); end
            if (t == 7) begin
                n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL mf_b: got %b expected 1", b); end
            end
        end
        n_checks++; if (result_count !== 16'd1) begin n_fail++; $display("FAIL mf_count: got %0d expected 1", result_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            if (t < 17) begin
                a = t[7:0]; op = t[1:0]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t == 19) begin
                n_checks++; if (result_count_w !== 4'd0) begin n_fail++; $display("FAIL wrap_at16: got %0d expected 0", result_count_w); end
            end
        end
        n_checks++; if (result_count !== 16'd17) begin n_fail++; $display("FAIL wrap_count16: got %0d expected 17", result_count); end
        n_checks++; if (result_count_w !== 4'd1) begin n_fail++; $display("FAIL wrap_count4: got %0d expected 1", result_count_w); end
    endtask

    task automatic test_sweep();
        logic        q2 [$];
        logic        q32 [$];
        logic        pend2, pend32, e;
        logic [31:0] r;
        pend2 = 1'b0; pend32 = 1'b0;
        do_reset();
        for (int c = 0; c < 412; c++) begin
            @(negedge clk);
            if (c < 400) begin
                r = $urandom;
                s2_rdy  = r[0] | r[1];
                s32_rdy = r[2] | r[3];
                if (!pend2) begin
                    s2_iv = r[4]; s2_op = r[6:5]; s2_a = r[8:7];
                end
                if (!pend32) begin
                    s32_iv = r[9]; s32_op = r[11:10]; s32_a = $urandom;
                end
            end else begin
                s2_iv = 1'b0; s32_iv = 1'b0; s2_rdy = 1'b1; s32_rdy = 1'b1;
            end
            #1;
            if (s2_iv && s2_ir) q2.push_back(ref_red(s2_op, {30'd0, s2_a}, 2));
            if (s32_iv && s32_ir) q32.push_back(ref_red(s32_op, s32_a, 32));
            if (s2_ov && s2_rdy) begin
                n_checks++;
                if (q2.size() == 0) begin
                    n_fail++; $display("FAIL sweep_w2_extra: got result %b expected none", s2_b);
                end else begin
                    e = q2.pop_front();
                    if (s2_b !== e) begin n_fail++; $display("FAIL sweep_w2_b[c=%0d]: got %b expected %b", c, s2_b, e); end
                end
            end
            if (s32_ov && s32_rdy) begin
                n_checks++;
                if (q32.size() == 0) begin
                    n_fail++; $display("FAIL sweep_w32_extra: got result %b expected none", s32_b);
                end else begin
                    e = q32.pop_front();
                    if (s32_b !== e) begin n_fail++; $display("FAIL sweep_w32_b[c=%0d]: got %b expected %b", c, s32_b, e); end
                end
            end
            pend2  = s2_iv && !s2_ir;
            pend32 = s32_iv && !s32_ir;
        end
        n_checks++; if (q2.size() != 0) begin n_fail++; $display("FAIL sweep_w2_lost: got %0d pending expected 0", q2.size()); end
        n_checks++; if (q32.size() != 0) begin n_fail++; $display("FAIL sweep_w32_lost: got %0d pending expected 0", q32.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_op_tracking();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reduce_pipe.md
REDUCE_PIPE -- requirements
Module: reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 8, input vector width; SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 16, width of the result counter.
REQ-003 Derived constant LEVELS = log2(WIDTH); this is the number of tree levels and the latency in cycles.
REQ-004 clk  input  1  sole clock; all state SHALL be updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  WIDTH  operand vector.
REQ-007 op  input  2  reduction select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 in_valid  input  1  a and op are valid.
REQ-009 in_ready  output  1  block accepts a/op this cycle.
REQ-010 b  output  1  reduction result.
REQ-011 out_valid  output  1  b is valid.
REQ-012 out_ready  input  1  consumer accepts b this cycle.
REQ-013 result_count  output  CNT_W  number of results delivered, modulo 2^CNT_W.

Function
REQ-014 The block SHALL compute a balanced binary tree of LEVELS stages; level k combines adjacent pairs of level k-1 and registers them.
- AND, OR and XOR SHALL apply the same 2-input operator at every level.
- NAND SHALL use AND at every level and invert only at the final level, so b = ~&a.
REQ-015 op SHALL be captured with a on acceptance and travel with its data through every level, so each transaction uses its own op independent of its neighbours.
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 stall = out_valid && !out_ready, and in_ready = !stall; these are combinational.
REQ-018 When stall is low, all levels SHALL advance one stage per cycle; when stall is high, every level's data, op and valid SHALL hold.
REQ-019 Level 1 valid SHALL load in_valid on each advance; level k valid SHALL load level k-1 valid.
- Bubbles SHALL propagate, and no transaction SHALL be dropped or duplicated.
REQ-020 Latency SHALL be exactly LEVELS cycles from an accepted input to out_valid, given no stall.
REQ-021 Throughput SHALL be one transaction per cycle with out_ready held high.
REQ-022 b SHALL be stable while out_valid && !out_ready.
REQ-023 result_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-024 When out_valid = 0, b SHALL hold its last value; it is not forced to 0.
REQ-025 An input presented while stalled SHALL NOT be accepted; the source SHALL hold it until in_ready is high.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear every level valid, level data, captured op, b and result_count to 0.
- After reset: out_valid = 0 and in_ready = 1.
REQ-027 Reset during operation SHALL discard all in-flight transactions; no output transfer SHALL occur for them.
REQ-028 The first rising clk after rst_n deasserts SHALL be able to accept an input.

Structure
REQ-029 A shared package reduce_pipe_pkg SHALL hold:
- the op enum (OP_AND, OP_OR, OP_XOR, OP_NAND);
- the pairwise-operator function;
- the log2 helper used to derive LEVELS.
REQ-030 One sub-module, reduce_stage, SHALL implement one tree level.
- Parameter: input width N.
- Function: pairwise reduction of N bits to N/2 bits, registered with an advance enable, plus valid and op pipeline registers.
- reduce_pipe SHALL instantiate it LEVELS times via a generate loop.

Verification (WIDTH=8 unless stated)
REQ-031 Basic reductions, out_ready=1:
- a=8'hFF, op=AND -> b=1, 3 cycles after acceptance;
- a=8'hFE, op=AND -> b=0;
- a=8'hFE, op=NAND -> b=1;
- a=8'h00, op=OR -> b=0.
REQ-032 Op tracking: back-to-back inputs {8'h01,XOR}, {8'h03,XOR}, {8'h80,OR}, {8'h00,NAND} with out_ready=1:
- b = 1, 0, 1, 1 on 4 consecutive cycles;
- result_count = 4.
REQ-033 Backpressure: fill the pipe, then drop out_ready for 5 cycles:
- in_ready=0 and b/out_valid held throughout;
- on release, all results emerge in order with none lost.
REQ-034 Reset mid-flight: assert rst_n low with 3 transactions in flight:
- out_valid=0 and result_count=0 immediately;
- the next input yields exactly one result after 3 cycles.
REQ-035 Counter wrap: CNT_W=4, 17 transfers -> result_count=1.
REQ-036 Parameter sweep: WIDTH=2 (latency 1) and WIDTH=32 (latency 5), random a, op and out_ready, checked against a reference model.
